reference_buffer_reader: RTL and testbench

- Initiator for the reference-buffer read interface: walks a contiguous, wrapping address range and issues one read per cycle while credit allows.
- Collects the returned I/Q samples, which arrive 2 cycles after issue with no backpressure, into a small output FIFO.
- Presents the samples as a valid/ready stream to the CAF correlator datapath.
- One read job per start pulse; done pulse when the last sample leaves the FIFO.

---
 rtl/reference_buffer_reader_pkg.sv | 21 ++
 rtl/reference_buffer_reader_iq_sync_fifo.sv | 54 +++++
 rtl/reference_buffer_reader.sv | 155 +++++++++++++++
 tb/tb_reference_buffer_reader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reference_buffer_reader_pkg.sv
// Shared types and constants for the reference-buffer reader and its output FIFO.
package reference_buffer_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_I_BITS = 12;
    localparam int DEFAULT_Q_BITS = 12;

    // Cycles from a request being driven to its sample arriving.
    localparam int RETURN_LATENCY = 2;

    typedef struct packed {
        logic signed [DEFAULT_I_BITS-1:0] i;
        logic signed [DEFAULT_Q_BITS-1:0] q;
    } iq_sample_t;

endpackage

// File: rtl/reference_buffer_reader_iq_sync_fifo.sv
// Shift-register FIFO: entry 0 is always the head, so the head is a plain register.
module iq_sync_fifo #(
    parameter int depth = 4,
    parameter int width = 24,
    localparam int count_bits = $clog2(depth + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [width-1:0]      push_data,
    input  logic                  pop,
    output logic [width-1:0]      head,
    output logic [count_bits-1:0] count,
    output logic                  empty,
    output logic                  full
);

    logic [width-1:0]      entries [depth];
    logic                  do_pop;
    logic                  do_push;
    logic [count_bits-1:0] wr_idx;

    assign empty   = (count == '0);
    assign full    = (count == count_bits'(depth));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // A simultaneous pop shifts everything down, so the new entry lands one slot lower.
    assign wr_idx  = count - count_bits'(do_pop);
    assign head    = entries[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < depth; k++) begin
                entries[k] <= '0;
            end
            count <= '0;
        end else begin
            for (int k = 0; k < depth - 1; k++) begin
                if (do_push && wr_idx == count_bits'(k)) begin
                    entries[k] <= push_data;
                end else if (do_pop) begin
                    entries[k] <= entries[k+1];
                end
            end
            if (do_push && wr_idx == count_bits'(depth - 1)) begin
                entries[depth-1] <= push_data;
            end else if (do_pop) begin
                entries[depth-1] <= '0;
            end
            count <= count + count_bits'(do_push) - count_bits'(do_pop);
        end
    end

endmodule

// File: rtl/reference_buffer_reader.sv
// Reference-buffer read initiator: issues wrapping-address reads under FIFO credit
// and streams the returned I/Q samples to the correlator.
//
// state | meaning
// IDLE  | waiting for start; validates the job
// RUN   | issuing reads while credit and s_axi_rready allow
// DRAIN | all reads issued; waiting for returns and the FIFO to empty
module reference_buffer_reader
    import reference_buffer_reader_pkg::*;
#(
    parameter int buffer_length = 10,
    parameter int index_bits    = 4,
    parameter int i_bits        = DEFAULT_I_BITS,
    parameter int q_bits        = DEFAULT_Q_BITS,
    parameter int count_bits    = 8,
    parameter int fifo_depth    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [index_bits-1:0] start_addr,
    input  logic [count_bits-1:0] read_count,
    output logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [index_bits-1:0] m_axi_raddr,
    input  logic                  s_axi_rready,
    input  logic [i_bits-1:0]     i_in,
    input  logic [q_bits-1:0]     q_in,
    input  logic                  s_axi_data_rvalid,
    output logic [i_bits-1:0]     out_i,
    output logic [q_bits-1:0]     out_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int credit_bits = $clog2(fifo_depth + 1);
    localparam logic [index_bits-1:0] last_addr = index_bits'(buffer_length - 1);

    typedef struct packed {
        logic signed [i_bits-1:0] i;
        logic signed [q_bits-1:0] q;
    } sample_t;

    state_t                 state;
    logic [index_bits-1:0]  addr;
    logic [count_bits-1:0]  job_count;
    logic [count_bits-1:0]  issued;
    logic [credit_bits-1:0] inflight;
    logic [credit_bits-1:0] fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   issue;
    logic                   ret_accept;
    logic                   pop;
    logic                   fifo_empty_next;
    sample_t                push_sample;
    sample_t                head_sample;

    assign push_sample.i = i_in;
    assign push_sample.q = q_in;

    iq_sync_fifo #(
        .depth (fifo_depth),
        .width ($bits(sample_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ret_accept),
        .push_data (push_sample),
        .pop       (pop),
        .head      (head_sample),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_i     = head_sample.i;
    assign out_q     = head_sample.q;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // Beats arriving with nothing outstanding are leftovers from before a reset.
    assign ret_accept = s_axi_data_rvalid && (inflight != '0);

    // Credit counts in-flight reads as already occupying FIFO slots, so returns never overflow.
    assign issue = !reset && (state == RUN) && s_axi_rready && (issued < job_count)
                   && !fifo_full
                   && (({1'b0, fifo_count} + {1'b0, inflight}) < (credit_bits + 1)'(fifo_depth));

    assign fifo_empty_next = fifo_empty
                             || (fifo_count == credit_bits'(1) && pop && !ret_accept);

    assign m_axi_rvalid = issue;
    assign m_axi_raddr  = addr;
    assign m_axi_rready = (state != IDLE);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            job_count <= '0;
            issued    <= '0;
            inflight  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (issue && !ret_accept) begin
                inflight <= inflight + 1'b1;
            end else if (!issue && ret_accept) begin
                inflight <= inflight - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (int'(start_addr) >= buffer_length) begin
                            err <= 1'b1;
                        end else if (read_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr      <= start_addr;
                            job_count <= read_count;
                            issued    <= '0;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr   <= (addr == last_addr) ? '0 : addr + 1'b1;
                        issued <= issued + 1'b1;
                        if (issued == job_count - 1'b1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Look one pop ahead so done lands the cycle after the last beat leaves.
                    if (inflight == '0 && fifo_empty_next) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reference_buffer_reader.sv
// Directed bench for reference_buffer_reader with a 2-cycle-latency buffer responder.
module tb_reference_buffer_reader;
    import reference_buffer_reader_pkg::*;

    localparam int BL = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  start_addr;
    logic [7:0]  read_count;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [3:0]  m_axi_raddr;
    logic        s_axi_rready;
    logic [11:0] i_in;
    logic [11:0] q_in;
    logic        s_axi_data_rvalid;
    logic [11:0] out_i;
    logic [11:0] out_q;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    reference_buffer_reader #(
        .buffer_length (BL),
        .index_bits    (4),
        .i_bits        (12),
        .q_bits        (12),
        .count_bits    (8),
        .fifo_depth    (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .start_addr        (start_addr),
        .read_count        (read_count),
        .m_axi_rvalid      (m_axi_rvalid),
        .m_axi_rready      (m_axi_rready),
        .m_axi_raddr       (m_axi_raddr),
        .s_axi_rready      (s_axi_rready),
        .i_in              (i_in),
        .q_in              (q_in),
        .s_axi_data_rvalid (s_axi_data_rvalid),
        .out_i             (out_i),
        .out_q             (out_q),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: entry k holds i=k, q=-k; a request seen in cycle N is returned in cycle N+2.
    logic [11:0] mem_i [16];
    logic [11:0] mem_q [16];
    logic        s1_v = 1'b0;
    logic        s2_v = 1'b0;
    logic [3:0]  s1_a = '0;
    logic [3:0]  s2_a = '0;

    always @(posedge clk) begin
        s1_v <= m_axi_rvalid;
        s1_a <= m_axi_raddr;
        s2_v <= s1_v;
        s2_a <= s1_a;
    end
    assign s_axi_data_rvalid = s2_v;
    assign i_in = mem_i[s2_a];
    assign q_in = mem_q[s2_a];

    // Monitor
    logic [23:0] got_q [$];
    logic [3:0]  addr_q [$];
    int done_cnt, err_cnt, busy_cycles, valid_cycles, rready_viol;
    int first_valid, last_pop, done_cyc, start_cycle;

    always @(negedge clk) begin
        if (m_axi_rvalid) begin
            addr_q.push_back(m_axi_raddr);
            if (!s_axi_rready) rready_viol++;
        end
        if (out_valid) begin
            valid_cycles++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (out_valid && out_ready) begin
            got_q.push_back({out_i, out_q});
            last_pop = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
        if (busy) busy_cycles++;
    end

    int checks = 0;
    int failures = 0;
    bit toggle_mode = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_sample(input int a);
        logic [11:0] iv;
        logic [11:0] qv;
        iv = 12'(a);
        qv = 12'(-a);
        return {iv, qv};
    endfunction

    task automatic clear_mon();
        got_q.delete();
        addr_q.delete();
        done_cnt = 0; err_cnt = 0; busy_cycles = 0; valid_cycles = 0; rready_viol = 0;
        first_valid = -1; last_pop = -1; done_cyc = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_mode) s_axi_rready = ~s_axi_rready;
    endtask

    task automatic pulse_start(input logic [3:0] sa, input logic [7:0] cnt);
        start_addr  = sa;
        read_count  = cnt;
        start       = 1'b1;
        start_cycle = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int t = 0;
        while (done_cnt == 0 && err_cnt == 0 && t < 400) begin
            step();
            t++;
        end
        check({name, " finished"}, longint'(done_cnt != 0 || err_cnt != 0), 1);
        repeat (3) step();
    endtask

    task automatic check_stream(input string name, input int sa, input int n);
        int bad = 0;
        check({name, " beats"}, got_q.size(), n);
        check({name, " issues"}, addr_q.size(), n);
        for (int j = 0; j < got_q.size() && j < n; j++)
            if (got_q[j] !== exp_sample((sa + j) % BL)) bad++;
        for (int j = 0; j < addr_q.size() && j < n; j++)
            if (int'(addr_q[j]) != (sa + j) % BL) bad++;
        check({name, " order"}, bad, 0);
    endtask

    typedef struct {
        logic [3:0] sa;
        logic [7:0] cnt;
        bit         toggle;
        int         exp_issues;
        int         exp_err;
        int         exp_done;
    } vec_t;

    vec_t vecs [7];

    initial begin
        for (int k = 0; k < 16; k++) begin
            mem_i[k] = 12'(k);
            mem_q[k] = 12'(-k);
        end
        vecs[0] = '{sa: 4'd0,  cnt: 8'd10, toggle: 1'b0, exp_issues: 10, exp_err: 0, exp_done: 1};
        vecs[1] = '{sa: 4'd7,  cnt: 8'd6,  toggle: 1'b0, exp_issues: 6,  exp_err: 0, exp_done: 1};
        vecs[2] = '{sa: 4'd10, cnt: 8'd5,  toggle: 1'b0, exp_issues: 0,  exp_err: 1, exp_done: 0};
        vecs[3] = '{sa: 4'd4,  cnt: 8'd0,  toggle: 1'b0, exp_issues: 0,  exp_err: 0, exp_done: 1};
        vecs[4] = '{sa: 4'd9,  cnt: 8'd13, toggle: 1'b0, exp_issues: 13, exp_err: 0, exp_done: 1};
        vecs[5] = '{sa: 4'd2,  cnt: 8'd5,  toggle: 1'b1, exp_issues: 5,  exp_err: 0, exp_done: 1};
        vecs[6] = '{sa: 4'd15, cnt: 8'd1,  toggle: 1'b0, exp_issues: 0,  exp_err: 1, exp_done: 0};

        reset = 1'b1; start = 1'b0; start_addr = '0; read_count = '0;
        s_axi_rready = 1'b1; out_ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("reset m_axi_rvalid", m_axi_rvalid, 0);
        check("reset m_axi_rready", m_axi_rready, 0);
        check("reset m_axi_raddr", m_axi_raddr, 0);
        check("reset out_iq", {out_i, out_q}, 0);
        check("reset out_valid", out_valid, 0);
        check("reset busy_done_err", {busy, done, err}, 0);
        reset = 1'b0;
        step();

        for (int n = 0; n < 7; n++) begin
            string name;
            name = $sformatf("vec%0d", n);
            clear_mon();
            toggle_mode  = vecs[n].toggle;
            s_axi_rready = 1'b1;
            out_ready    = 1'b1;
            pulse_start(vecs[n].sa, vecs[n].cnt);
            wait_end(name);
            toggle_mode  = 1'b0;
            s_axi_rready = 1'b1;
            check({name, " err"}, err_cnt, vecs[n].exp_err);
            check({name, " done"}, done_cnt, vecs[n].exp_done);
            check_stream(name, int'(vecs[n].sa), vecs[n].exp_issues);
            check({name, " busy after"}, busy, 0);
            check({name, " rvalid w/o rready"}, rready_viol, 0);
            if (vecs[n].exp_err != 0 || vecs[n].cnt == 0)
                check({name, " busy cycles"}, busy_cycles, 0);
            if (vecs[n].exp_done != 0)
                check({name, " done cycle"}, done_cyc,
                      (vecs[n].cnt == 0) ? start_cycle + 1 : last_pop + 1);
            if (vecs[n].exp_issues > 0 && !vecs[n].toggle)
                check({name, " first valid cycle"}, first_valid, start_cycle + 4);
        end

        // Backpressure: no pops for 20 cycles, credit must cap issues at the FIFO depth.
        clear_mon();
        out_ready = 1'b0;
        pulse_start(4'd0, 8'd10);
        repeat (20) step();
        check("bp issues held", addr_q.size(), 4);
        check("bp out_valid held", out_valid, 1);
        check("bp no pops", got_q.size(), 0);
        out_ready = 1'b1;
        wait_end("bp");
        check_stream("bp", 0, 10);
        check("bp done", done_cnt, 1);

        // Reset one cycle after the second issue, with two returns still on the way.
        clear_mon();
        pulse_start(4'd0, 8'd10);
        step();
        step();
        check("rst issues before", addr_q.size(), 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (8) step();
        check("rst out_valid cycles", valid_cycles, 0);
        check("rst issues total", addr_q.size(), 2);
        check("rst busy", busy, 0);
        clear_mon();
        pulse_start(4'd3, 8'd2);
        wait_end("post rst");
        check_stream("post rst", 3, 2);
        check("post rst done", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
